adc_byte_scheduler: RTL and testbench

Shares one byte-wide transmit path, normally the UART TX, between up to 16 ADC capture channels. Each channel delivers 32-bit samples with a one-cycle strobe. The block holds one pending sample per channel and grants channels round-robin. Each granted sample is sent as a 5-byte frame: a channel header byte followed by the sample MSB-first. It sits between the ADC capture blocks and the serial transmitter and handles all byte sequencing and backpressure.

---
 rtl/adc_byte_scheduler_pkg.sv | 27 ++
 rtl/adc_byte_scheduler_if.sv | 23 ++
 rtl/adc_byte_scheduler_rr_arbiter.sv | 30 +++
 rtl/adc_byte_scheduler.sv | 114 +++++++++++
 tb/tb_adc_byte_scheduler.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/adc_byte_scheduler_pkg.sv
// Shared types and constants for the ADC byte scheduler.
// Frame layout is {tag, channel, sample[31:0]}, sent header first, then the sample MSB first.
package adc_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sched_state_t;

    localparam int         BYTES_PER_FRAME = 5;
    localparam logic [3:0] HDR_TAG_DEFAULT = 4'hA;
    localparam int         MAX_NCH         = 16;

    function automatic logic [7:0] frame_byte(input logic [39:0] frame, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = frame[39:32];
            3'd1:    b = frame[31:24];
            3'd2:    b = frame[23:16];
            3'd3:    b = frame[15:8];
            3'd4:    b = frame[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/adc_byte_scheduler_if.sv
// Sample-in / byte-out bundle between the ADC capture blocks, the scheduler and the byte sink.
interface adc_byte_scheduler_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0]     new_data;
    logic [32*NCH-1:0]  adc_data;
    logic               tx_ready;
    logic               tx_valid;
    logic [7:0]         tx_byte;
    logic [NCH-1:0]     overrun;
    logic               clr_overrun;
    logic               busy;

    modport master (
        output new_data, adc_data, tx_ready, clr_overrun,
        input  tx_valid, tx_byte, overrun, busy
    );

    modport slave (
        input  new_data, adc_data, tx_ready, clr_overrun,
        output tx_valid, tx_byte, overrun, busy
    );
endinterface

// File: rtl/adc_byte_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request at or above i_ptr, wrapping modulo NCH.
module rr_arbiter
    import adc_sched_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]               i_req,
    input  logic [$clog2(MAX_NCH)-1:0]   i_ptr,
    output logic [NCH-1:0]               o_gnt,
    output logic [$clog2(MAX_NCH)-1:0]   o_gnt_idx,
    output logic                         o_any
);

    // Outer loop walks the search order; inner loop keeps every index constant.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!o_any && i_req[c] && (c == ((int'(i_ptr) + k) % NCH))) begin
                    o_any     = 1'b1;
                    o_gnt[c]  = 1'b1;
                    o_gnt_idx = ($clog2(MAX_NCH))'(c);
                end
            end
        end
    end

endmodule

// File: rtl/adc_byte_scheduler.sv
// Shares one byte sink between NCH ADC channels: one pending sample per channel,
// round-robin grant, 5-byte frame per sample with valid/ready backpressure.
//
//   state | meaning
//   IDLE  | no frame in flight; grants the next pending channel if any
//   SEND  | offering frame byte r_byte_cnt, advancing on tx_ready
module adc_byte_scheduler
    import adc_sched_pkg::*;
#(
    parameter int         NCH     = 4,
    parameter logic [3:0] HDR_TAG = HDR_TAG_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adc_byte_scheduler_if.slave   bus
);

    sched_state_t   r_state;
    sched_state_t   w_state_nxt;
    logic [31:0]    r_hold [NCH];
    logic [NCH-1:0] r_pending;
    logic [NCH-1:0] r_overrun;
    logic [3:0]     r_rr_ptr;
    logic [2:0]     r_byte_cnt;
    logic [39:0]    r_frame;

    logic [NCH-1:0] w_gnt;
    logic [NCH-1:0] w_take;
    logic [NCH-1:0] w_ovr_set;
    logic [3:0]     w_gnt_idx;
    logic [31:0]    w_sel_hold;
    logic           w_any;
    logic           w_grant;
    logic           w_accept;
    logic           w_last;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .i_req     (r_pending),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    assign w_grant   = (r_state == IDLE) && w_any;
    assign w_take    = {NCH{w_grant}} & w_gnt;
    // A strobe on the channel being granted refills it instead of counting as an overrun.
    assign w_ovr_set = bus.new_data & r_pending & ~w_take;
    assign w_accept  = (r_state == SEND) && bus.tx_ready;
    assign w_last    = (r_byte_cnt == 3'(BYTES_PER_FRAME - 1));

    always_comb begin
        w_sel_hold = '0;
        for (int c = 0; c < NCH; c++) begin
            if (w_gnt[c]) w_sel_hold = r_hold[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_nxt = SEND;
            SEND:    if (w_accept && w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.tx_valid = 1'b0;
        bus.tx_byte  = 8'h00;
        if (r_state == SEND) begin
            bus.tx_valid = 1'b1;
            bus.tx_byte  = frame_byte(r_frame, r_byte_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_overrun <= '0;
            for (int i = 0; i < NCH; i++) r_hold[i] <= '0;
        end else begin
            r_pending <= (r_pending & ~w_take) | bus.new_data;
            r_overrun <= w_ovr_set | (r_overrun & ~{NCH{bus.clr_overrun}});
            for (int i = 0; i < NCH; i++) begin
                if (bus.new_data[i] && (!r_pending[i] || w_take[i]))
                    r_hold[i] <= bus.adc_data[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame    <= '0;
            r_rr_ptr   <= '0;
            r_byte_cnt <= '0;
        end else if (w_grant) begin
            r_frame    <= {HDR_TAG, w_gnt_idx, w_sel_hold};
            r_rr_ptr   <= (w_gnt_idx == 4'(NCH - 1)) ? 4'd0 : w_gnt_idx + 4'd1;
            r_byte_cnt <= '0;
        end else if (w_accept && !w_last) begin
            r_byte_cnt <= r_byte_cnt + 3'd1;
        end
    end

    assign bus.overrun = r_overrun;
    assign bus.busy    = (r_state == SEND) || (|r_pending);

endmodule

// File: tb/tb_adc_byte_scheduler.sv
// Directed bench for adc_byte_scheduler: per-cycle vector table plus a mid-frame reset sequence.
module tb_adc_byte_scheduler;

    localparam int NCH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adc_byte_scheduler_if #(.NCH(NCH)) bus ();

    adc_byte_scheduler #(.NCH(NCH), .HDR_TAG(4'hA)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]   nd;
        logic [127:0] ad;
        logic         rdy;
        logic         clr;
        logic         ev;
        logic [7:0]   eb;
        logic         ebusy;
        logic [3:0]   eov;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [127:0] ch(input int i, input logic [31:0] v);
        logic [127:0] w;
        w = {96'd0, v};
        return w << (32 * i);
    endfunction

    task automatic add(input logic [3:0] nd, input logic [127:0] ad, input logic rdy,
                       input logic clr, input logic ev, input logic [7:0] eb,
                       input logic ebusy, input logic [3:0] eov);
        vec_t v;
        v.nd = nd; v.ad = ad; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.eb = eb; v.ebusy = ebusy; v.eov = eov;
        vecs.push_back(v);
    endtask

    task automatic idle(input logic ebusy, input logic [3:0] eov);
        add(4'b0, 128'd0, 1'b1, 1'b0, 1'b0, 8'h00, ebusy, eov);
    endtask

    task automatic byt(input logic [7:0] eb, input logic [3:0] eov);
        add(4'b0, 128'd0, 1'b1, 1'b0, 1'b1, eb, 1'b1, eov);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] nd, input logic [127:0] ad, input logic rdy, input logic clr);
        bus.new_data    = nd;
        bus.adc_data    = ad;
        bus.tx_ready    = rdy;
        bus.clr_overrun = clr;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(4'b0, 128'd0, 1'b0, 1'b0);

        // Round robin: ch0 and ch3 together, ch0 again while its first frame is still sending
        add(4'b1001, ch(0, 32'h1) | ch(3, 32'h3), 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0);
        idle(1'b1, 4'h0);
        byt(8'hA0, 4'h0); byt(8'h00, 4'h0);
        add(4'b0001, ch(0, 32'h10), 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 4'h0);
        byt(8'h00, 4'h0); byt(8'h01, 4'h0);
        idle(1'b1, 4'h0);
        byt(8'hA3, 4'h0); byt(8'h00, 4'h0); byt(8'h00, 4'h0); byt(8'h00, 4'h0); byt(8'h03, 4'h0);
        idle(1'b1, 4'h0);
        byt(8'hA0, 4'h0); byt(8'h00, 4'h0); byt(8'h00, 4'h0); byt(8'h00, 4'h0); byt(8'h10, 4'h0);
        idle(1'b0, 4'h0);

        // Single frame, sink always ready
        add(4'b0100, ch(2, 32'h12345678), 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0);
        idle(1'b1, 4'h0);
        byt(8'hA2, 4'h0); byt(8'h12, 4'h0); byt(8'h34, 4'h0); byt(8'h56, 4'h0); byt(8'h78, 4'h0);
        idle(1'b0, 4'h0);

        // Backpressure on byte 0x34 for three cycles
        add(4'b0100, ch(2, 32'h12345678), 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0);
        idle(1'b1, 4'h0);
        byt(8'hA2, 4'h0); byt(8'h12, 4'h0);
        for (int k = 0; k < 3; k++) add(4'b0, 128'd0, 1'b0, 1'b0, 1'b1, 8'h34, 1'b1, 4'h0);
        byt(8'h34, 4'h0); byt(8'h56, 4'h0); byt(8'h78, 4'h0);
        idle(1'b0, 4'h0);

        // Overrun on ch1 while ch2 sends; clear in the same cycle as the set must lose
        add(4'b0100, ch(2, 32'h0), 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0);
        add(4'b0010, ch(1, 32'hAAAAAAAA), 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 4'h0);
        add(4'b0010, ch(1, 32'hBBBBBBBB), 1'b1, 1'b1, 1'b1, 8'hA2, 1'b1, 4'h0);
        for (int k = 0; k < 4; k++) byt(8'h00, 4'b0010);
        idle(1'b1, 4'b0010);
        byt(8'hA1, 4'b0010);
        for (int k = 0; k < 4; k++) byt(8'hAA, 4'b0010);
        add(4'b0, 128'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0010);
        idle(1'b0, 4'h0);

        // Strobe on ch0 in the same cycle as its grant
        add(4'b0001, ch(0, 32'h11111111), 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0);
        add(4'b0001, ch(0, 32'h22222222), 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 4'h0);
        byt(8'hA0, 4'h0);
        for (int k = 0; k < 4; k++) byt(8'h11, 4'h0);
        idle(1'b1, 4'h0);
        byt(8'hA0, 4'h0);
        for (int k = 0; k < 4; k++) byt(8'h22, 4'h0);
        idle(1'b0, 4'h0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("reset tx_byte",  64'(bus.tx_byte),  64'h00);
        chk("reset busy",     64'(bus.busy),     64'd0);
        chk("reset overrun",  64'(bus.overrun),  64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            drive(vecs[i].nd, vecs[i].ad, vecs[i].rdy, vecs[i].clr);
            @(negedge clk);
            chk($sformatf("row%0d tx_valid", i), 64'(bus.tx_valid), 64'(vecs[i].ev));
            if (vecs[i].ev)
                chk($sformatf("row%0d tx_byte", i), 64'(bus.tx_byte), 64'(vecs[i].eb));
            chk($sformatf("row%0d busy", i), 64'(bus.busy), 64'(vecs[i].ebusy));
            chk($sformatf("row%0d overrun", i), 64'(bus.overrun), 64'(vecs[i].eov));
        end

        // Reset during byte 2 of a frame, with an overrun and another channel pending
        @(posedge clk); #1 drive(4'b0100, ch(2, 32'h12345678), 1'b1, 1'b0);
        @(posedge clk); #1 drive(4'b0010, ch(1, 32'hAAAAAAAA), 1'b1, 1'b0);
        @(posedge clk); #1 drive(4'b0010, ch(1, 32'hBBBBBBBB), 1'b1, 1'b0);
        @(posedge clk); #1 drive(4'b0001, ch(0, 32'h55), 1'b1, 1'b0);
        @(posedge clk); #1 drive(4'b0, 128'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("pre-reset tx_byte", 64'(bus.tx_byte), 64'h34);
        chk("pre-reset overrun", 64'(bus.overrun), 64'b0010);
        rst_n = 1'b0;
        #1;
        chk("mid-frame reset tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("mid-frame reset tx_byte",  64'(bus.tx_byte),  64'h00);
        chk("mid-frame reset busy",     64'(bus.busy),     64'd0);
        chk("mid-frame reset overrun",  64'(bus.overrun),  64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("post-reset quiet tx_valid c%0d", k), 64'(bus.tx_valid), 64'd0);
            chk($sformatf("post-reset quiet busy c%0d", k), 64'(bus.busy), 64'd0);
        end
        @(posedge clk); #1 drive(4'b1000, ch(3, 32'h9ABCDEF0), 1'b1, 1'b0);
        @(posedge clk); #1 drive(4'b0, 128'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("post-reset latency tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("post-reset latency busy",     64'(bus.busy),     64'd1);
        @(negedge clk);
        chk("post-reset header valid", 64'(bus.tx_valid), 64'd1);
        chk("post-reset header byte",  64'(bus.tx_byte),  64'hA3);
        @(negedge clk);
        chk("post-reset first data byte", 64'(bus.tx_byte), 64'h9A);

        repeat (8) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
